dma_read_engine: RTL and testbench

DMA_READ_ENGINE -- requirements
Module: dma_read_engine

---
 rtl/dma_read_engine.sv | 141 ++++++++++++++
 tb/tb_dma_read_engine.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/dma_read_engine.sv
// dma_read_engine: chunked DMA read command generator; completion by beat counting. Optional keep check: DMA_READ_KEEP_CHECK_EN.
// Commands registered, held until ready; the data input is always ready once out of reset and is never backpressured.
module dma_read_engine (
  input  logic               clk,
  input  logic               rstn,
  output logic               m_axis_dma_read_cmd_valid,
  input  logic               m_axis_dma_read_cmd_ready,
  output logic [63:0]        m_axis_dma_read_cmd_address,
  output logic [31:0]        m_axis_dma_read_cmd_length,
  input  logic               s_axis_dma_read_data_valid,
  output logic               s_axis_dma_read_data_ready,
  input  logic [511:0]       s_axis_dma_read_data_data,
  input  logic [63:0]        s_axis_dma_read_data_keep,
  input  logic               s_axis_dma_read_data_last,
  input  logic [15:0][31:0]  control_reg,
  output logic [15:0][31:0]  status_reg
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic        start_q, armed, start, busy;
  logic [63:0] next_addr;
  logic [31:0] total_q, chunk_q, max_q;
  logic [26:0] beats_per_cmd, comp_beat;
  logic [31:0] bytes_issued, cmds_issued, cmds_done, beats_rx, cycles;
  logic        done_flag;

  logic        accept, cmd_fire, rx_done, can_issue;
  logic [31:0] rx_next, remaining, max_eff, outstanding, next_len;

  // armed blocks a spurious edge on the first cycle after reset while the start bit is still high
  assign start     = armed && control_reg[7][1] && !start_q && (state == IDLE);
  assign accept    = s_axis_dma_read_data_ready && s_axis_dma_read_data_valid && (state == RUN);
  assign cmd_fire  = m_axis_dma_read_cmd_valid && m_axis_dma_read_cmd_ready;
  assign rx_next   = beats_rx + {31'd0, accept};
  assign rx_done   = ({rx_next, 6'd0} >= {6'd0, total_q}) || (chunk_q == 32'd0);
  assign remaining = total_q - bytes_issued;
  assign max_eff   = (max_q == 32'd0) ? 32'd1 : max_q;
  assign outstanding = cmds_issued - cmds_done;
  assign next_len  = (chunk_q < remaining) ? chunk_q : remaining;
  assign can_issue = (state == RUN) && !m_axis_dma_read_cmd_valid && !rx_done &&
                     (bytes_issued < total_q) && (outstanding < max_eff);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (rx_done) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      start_q <= 1'b0;  armed <= 1'b0;  s_axis_dma_read_data_ready <= 1'b0;
      m_axis_dma_read_cmd_valid <= 1'b0;
      m_axis_dma_read_cmd_address <= '0;  m_axis_dma_read_cmd_length <= '0;
      next_addr <= '0;  total_q <= '0;  chunk_q <= '0;  max_q <= '0;
      beats_per_cmd <= '0;  comp_beat <= '0;  bytes_issued <= '0;
      cmds_issued <= '0;  cmds_done <= '0;  beats_rx <= '0;  cycles <= '0;
      done_flag <= 1'b0;
    end else begin
      start_q <= control_reg[7][1];
      armed   <= 1'b1;
      s_axis_dma_read_data_ready <= 1'b1;
      if (start) begin
        next_addr     <= {control_reg[1], control_reg[0]};
        total_q       <= control_reg[4];
        max_q         <= control_reg[5];
        chunk_q       <= control_reg[6];
        beats_per_cmd <= {1'b0, control_reg[6][31:6]} + {26'd0, |control_reg[6][5:0]};
        comp_beat <= '0;  bytes_issued <= '0;  cmds_issued <= '0;
        cmds_done <= '0;  beats_rx <= '0;  cycles <= '0;
        done_flag <= 1'b0;
        m_axis_dma_read_cmd_valid <= 1'b0;
      end else begin
        if (state == RUN) begin
          cycles   <= cycles + 32'd1;
          beats_rx <= rx_next;
          if (rx_done) done_flag <= 1'b1;
        end
        // in-order completion: every command except a trailing short one spans beats_per_cmd beats
        if (accept && (cmds_done != cmds_issued)) begin
          if (comp_beat + 27'd1 == beats_per_cmd) begin
            comp_beat <= '0;
            cmds_done <= cmds_done + 32'd1;
          end else begin
            comp_beat <= comp_beat + 27'd1;
          end
        end
        if (cmd_fire) begin
          m_axis_dma_read_cmd_valid <= 1'b0;
          next_addr    <= next_addr + {32'd0, chunk_q};
          bytes_issued <= bytes_issued + m_axis_dma_read_cmd_length;
          cmds_issued  <= cmds_issued + 32'd1;
        end
        if (can_issue) begin
          m_axis_dma_read_cmd_valid   <= 1'b1;
          m_axis_dma_read_cmd_address <= next_addr;
          m_axis_dma_read_cmd_length  <= next_len;
        end
        if (state != RUN) m_axis_dma_read_cmd_valid <= 1'b0;
      end
    end
  end

`ifdef DMA_READ_KEEP_CHECK_EN
  logic [31:0] keep_err;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                          keep_err <= '0;
    else if (start)                                     keep_err <= '0;
    else if (accept && (s_axis_dma_read_data_keep != '1)) keep_err <= keep_err + 32'd1;
  end
`endif

  always_comb begin
    busy       = (state == RUN);
    status_reg = '0;
    status_reg[0][0] = busy;
    status_reg[0][1] = done_flag;
    status_reg[1]    = cycles;
    status_reg[2]    = beats_rx;
    status_reg[3]    = cmds_issued;
`ifdef DMA_READ_KEEP_CHECK_EN
    status_reg[4]    = keep_err;
`endif
  end

  // payload and tlast are deliberately not inspected; unlisted control words are ignored
  logic unused_bits;
  assign unused_bits = ^{s_axis_dma_read_data_data, s_axis_dma_read_data_keep,
                         s_axis_dma_read_data_last, control_reg};

endmodule

// File: tb/tb_dma_read_engine.sv
// Directed bench for dma_read_engine: vector table of full transfers plus hand sequences for stall, gating, keep and reset.
module tb_dma_read_engine;
  logic              clk = 1'b0;
  logic              rstn;
  logic              cmd_valid, cmd_ready;
  logic [63:0]       cmd_address;
  logic [31:0]       cmd_length;
  logic              data_valid, data_ready, data_last;
  logic [511:0]      data_data;
  logic [63:0]       data_keep;
  logic [15:0][31:0] control_reg, status_reg;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dma_read_engine dut (
    .clk(clk), .rstn(rstn),
    .m_axis_dma_read_cmd_valid(cmd_valid), .m_axis_dma_read_cmd_ready(cmd_ready),
    .m_axis_dma_read_cmd_address(cmd_address), .m_axis_dma_read_cmd_length(cmd_length),
    .s_axis_dma_read_data_valid(data_valid), .s_axis_dma_read_data_ready(data_ready),
    .s_axis_dma_read_data_data(data_data), .s_axis_dma_read_data_keep(data_keep),
    .s_axis_dma_read_data_last(data_last),
    .control_reg(control_reg), .status_reg(status_reg)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [63:0] base;
    logic [31:0] total, chunk, maxo;
    logic        dvalid;
    int          exp_cmds, exp_beats, exp_cycles;
    logic [63:0] exp_last_addr;
    logic [31:0] exp_last_len;
  } vec_t;

  vec_t vecs[5];

  task automatic arm_start(input logic [63:0] base, input logic [31:0] total,
                           input logic [31:0] chunk, input logic [31:0] maxo);
    @(negedge clk);
    control_reg[7][1] = 1'b0;
    control_reg[0] = base[31:0];
    control_reg[1] = base[63:32];
    control_reg[4] = total;
    control_reg[5] = maxo;
    control_reg[6] = chunk;
    repeat (2) @(negedge clk);
    control_reg[7][1] = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          hs = 0;
    logic        got_done = 1'b0;
    logic [63:0] first_a = '0, last_a = '0;
    logic [31:0] last_l = '0;
    data_valid = v.dvalid;
    data_keep  = '1;
    cmd_ready  = 1'b1;
    arm_start(v.base, v.total, v.chunk, v.maxo);
    for (int c = 0; c < 10000 && !got_done; c++) begin
      @(negedge clk);
      if (cmd_valid && cmd_ready) begin
        if (hs == 0) first_a = cmd_address;
        last_a = cmd_address;
        last_l = cmd_length;
        hs++;
      end
      if (status_reg[0][1]) got_done = 1'b1;
    end
    check($sformatf("v%0d_done", idx), got_done, 1);
    check($sformatf("v%0d_cmds_seen", idx), hs, v.exp_cmds);
    check($sformatf("v%0d_stat_cmds", idx), status_reg[3], v.exp_cmds);
    check($sformatf("v%0d_stat_beats", idx), status_reg[2], v.exp_beats);
    check($sformatf("v%0d_stat_cycles", idx), status_reg[1], v.exp_cycles);
    check($sformatf("v%0d_stat_word0", idx), status_reg[0], 2);
    if (v.exp_cmds > 0) begin
      check($sformatf("v%0d_first_addr", idx), first_a, v.base);
      check($sformatf("v%0d_last_addr", idx), last_a, v.exp_last_addr);
      check($sformatf("v%0d_last_len", idx), last_l, v.exp_last_len);
    end
    control_reg[7][1] = 1'b0;
  endtask

  initial begin
    int          hs, beats, beats_at_second;
    logic        seen2, got, stable_ok, any_valid;
    logic [63:0] a0;
    logic [31:0] l0;

    vecs[0] = '{64'h0000_1234_1234_0000, 32'h40000, 32'h8000, 32'd16, 1'b1, 8, 4096, 4096,
                64'h0000_1234_1237_8000, 32'h8000};
    vecs[1] = '{64'h0000_0000_0000_1000, 32'h9000, 32'h8000, 32'd4, 1'b1, 2, 576, 576,
                64'h0000_0000_0000_9000, 32'h1000};
    vecs[2] = '{64'h0000_0000_0000_2000, 32'h0, 32'h8000, 32'd4, 1'b0, 0, 0, 1, 64'h0, 32'h0};
    vecs[3] = '{64'h0000_0000_0000_2000, 32'h1000, 32'h0, 32'd4, 1'b0, 0, 0, 1, 64'h0, 32'h0};
    vecs[4] = '{64'hFFFF_FFFF_FFFF_C000, 32'h8000, 32'h4000, 32'd2, 1'b1, 2, 512, 512,
                64'h0, 32'h4000};

    rstn = 1'b0;  cmd_ready = 1'b0;  data_valid = 1'b0;  data_last = 1'b0;
    data_data = '0;  data_keep = '1;  control_reg = '0;
    repeat (3) @(negedge clk);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_cmd_addr", cmd_address, 0);
    check("rst_cmd_len", cmd_length, 0);
    check("rst_data_ready", data_ready, 0);
    check("rst_status_zero", (status_reg == '0), 1);
    rstn = 1'b1;
    @(negedge clk);
    check("post_rst_data_ready", data_ready, 1);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // one outstanding command: the second may appear only after 512 beats of the first
    data_valid = 1'b1;  data_keep = '1;  cmd_ready = 1'b1;
    arm_start(64'h0, 32'h10000, 32'h8000, 32'd1);
    hs = 0;  beats = 0;  seen2 = 1'b0;  beats_at_second = 0;  got = 1'b0;
    for (int c = 0; c < 3000 && !got; c++) begin
      @(negedge clk);
      if (cmd_valid) begin
        if (hs == 1 && !seen2) begin seen2 = 1'b1; beats_at_second = beats; end
        if (cmd_ready) hs++;
      end
      if (status_reg[0][0] && data_valid && data_ready) beats++;
      if (status_reg[0][1]) got = 1'b1;
    end
    check("mo1_second_seen", seen2, 1);
    check("mo1_gated_512", (beats_at_second >= 512), 1);
    check("mo1_done", got, 1);
    check("mo1_cmds", status_reg[3], 2);
    control_reg[7][1] = 1'b0;

    // ready stalled 20 cycles with max outstanding 0 (acts as 1)
    data_valid = 1'b0;  cmd_ready = 1'b0;
    arm_start(64'h5000, 32'h2000, 32'h1000, 32'd0);
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (cmd_valid) got = 1'b1;
    end
    check("stall_valid_seen", got, 1);
    a0 = cmd_address;  l0 = cmd_length;
    check("stall_addr", a0, 64'h5000);
    check("stall_len", l0, 32'h1000);
    stable_ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!cmd_valid || cmd_address !== a0 || cmd_length !== l0) stable_ok = 1'b0;
    end
    check("stall_stable", stable_ok, 1);
    cmd_ready = 1'b1;
    hs = 0;
    for (int c = 0; c < 10; c++) begin
      if (cmd_valid && cmd_ready) hs++;
      @(negedge clk);
    end
    check("stall_one_transfer", hs, 1);
    data_valid = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 500 && !got; c++) begin
      @(negedge clk);
      if (status_reg[0][1]) got = 1'b1;
    end
    check("stall_done", got, 1);
    check("stall_cmds", status_reg[3], 2);
    check("stall_beats", status_reg[2], 128);
    control_reg[7][1] = 1'b0;

    // partial keep on the first three of eight beats
    data_valid = 1'b0;  cmd_ready = 1'b1;
    arm_start(64'h0, 32'h200, 32'h200, 32'd4);
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (status_reg[0][0]) got = 1'b1;
    end
    check("keep_busy", got, 1);
    for (int i = 0; i < 8; i++) begin
      data_keep  = (i < 3) ? 64'h0F : '1;
      data_valid = 1'b1;
      @(negedge clk);
    end
    data_valid = 1'b0;  data_keep = '1;
    check("keep_done", status_reg[0][1], 1);
    check("keep_beats", status_reg[2], 8);
`ifdef DMA_READ_KEEP_CHECK_EN
    check("keep_err_count", status_reg[4], 3);
`else
    check("keep_err_count", status_reg[4], 0);
`endif
    control_reg[7][1] = 1'b0;

    // reset mid-run, then require a fresh start edge
    data_valid = 1'b1;  cmd_ready = 1'b1;
    arm_start(64'h0, 32'h40000, 32'h8000, 32'd16);
    repeat (30) @(negedge clk);
    check("rr_busy_before", status_reg[0][0], 1);
    #2 rstn = 1'b0;
    #1;
    check("rr_cmd_valid", cmd_valid, 0);
    check("rr_cmd_addr", cmd_address, 0);
    check("rr_cmd_len", cmd_length, 0);
    check("rr_data_ready", data_ready, 0);
    check("rr_status_zero", (status_reg == '0), 1);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    any_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (cmd_valid || status_reg[0][0]) any_valid = 1'b1;
    end
    check("rr_no_restart", any_valid, 0);
    control_reg[7][1] = 1'b0;
    repeat (2) @(negedge clk);
    control_reg[7][1] = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (cmd_valid) got = 1'b1;
    end
    check("rr_new_start_cmd", got, 1);
    rstn = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
